// File: rtl/mbist_mem_arb.sv
// mbist_mem_arb
//   Two-master arbiter for a single SRAM port. Master 0 is the wishbone burst
//   path and master 1 is the BIST engine. Ties go round-robin, and the first
//   tie after reset goes to master 0. An owner that holds the port while the
//   other master waits is preempted after MAX_HOLD cycles, unless its lock is
//   high. Reads are tagged with the issuing master so that data returning two
//   cycles later reaches that master even if ownership has changed.
//
//   Build option: define MBIST_ARB_TURNAROUND_EN to insert one idle TURN
//   cycle after every ownership exit.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   mN_req, mN_lock             master N request / burst lock (N = 0, 1)
//   mN_cs/addr/we/wmask/wdata   master N access attributes
//   mN_gnt                      master N owns the SRAM port (registered)
//   mN_rvalid, mN_rdata         read data return to master N
//   mem_req/cs/addr/we/wmask/wdata, mem_rdata   shared SRAM port
//   arb_busy                    arbiter not idle (registered)
module mbist_mem_arb #(
    parameter int BIST_ADDR_WD = 9,
    parameter int BIST_DATA_WD = 32,
    parameter int BIST_CS_WD   = 2,
    parameter int MAX_HOLD     = 16
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,

    input  logic                      m0_req,
    input  logic                      m0_lock,
    input  logic [BIST_CS_WD-1:0]     m0_cs,
    input  logic [BIST_ADDR_WD-1:0]   m0_addr,
    input  logic                      m0_we,
    input  logic [BIST_DATA_WD/8-1:0] m0_wmask,
    input  logic [BIST_DATA_WD-1:0]   m0_wdata,
    output logic                      m0_gnt,
    output logic                      m0_rvalid,
    output logic [BIST_DATA_WD-1:0]   m0_rdata,

    input  logic                      m1_req,
    input  logic                      m1_lock,
    input  logic [BIST_CS_WD-1:0]     m1_cs,
    input  logic [BIST_ADDR_WD-1:0]   m1_addr,
    input  logic                      m1_we,
    input  logic [BIST_DATA_WD/8-1:0] m1_wmask,
    input  logic [BIST_DATA_WD-1:0]   m1_wdata,
    output logic                      m1_gnt,
    output logic                      m1_rvalid,
    output logic [BIST_DATA_WD-1:0]   m1_rdata,

    output logic                      mem_req,
    output logic [BIST_CS_WD-1:0]     mem_cs,
    output logic [BIST_ADDR_WD-1:0]   mem_addr,
    output logic                      mem_we,
    output logic [BIST_DATA_WD/8-1:0] mem_wmask,
    output logic [BIST_DATA_WD-1:0]   mem_wdata,
    input  logic [BIST_DATA_WD-1:0]   mem_rdata,

    output logic                      arb_busy
);

    // +2 keeps the counter at least one bit wide even for MAX_HOLD = 0
    localparam int HOLD_WD = $clog2(MAX_HOLD + 2);
    localparam logic [HOLD_WD-1:0] HOLD_MAX = HOLD_WD'(MAX_HOLD);

`ifdef MBIST_ARB_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
`endif

    state_t               state;
    state_t               state_nxt;
    logic                 rr_last;
    logic [HOLD_WD-1:0]   hold_cnt;
    logic                 own_req;
    logic                 own_lock;
    logic                 oth_req;
    logic                 leave;
    logic                 sel1;

    // read-return pipeline: {valid, owner} per stage
    logic                 rd_v0, rd_o0, rd_v1, rd_o1;

    always_comb begin
        sel1     = (state == OWN1);
        own_req  = sel1 ? m1_req  : m0_req;
        own_lock = sel1 ? m1_lock : m0_lock;
        oth_req  = sel1 ? m0_req  : m1_req;
        // only meaningful while in OWN0/OWN1
        leave    = !own_lock && (!own_req || hold_cnt == HOLD_MAX);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OWN0, OWN1: begin
                if (leave) begin
`ifdef MBIST_ARB_TURNAROUND_EN
                    state_nxt = TURN;
`else
                    if (oth_req)
                        state_nxt = (state == OWN0) ? OWN1 : OWN0;
                    else
                        state_nxt = IDLE;
`endif
                end
            end
            default: begin
                // IDLE, and TURN when present, arbitrate afresh
                if (m0_req && m1_req)
                    state_nxt = rr_last ? OWN0 : OWN1;
                else if (m0_req)
                    state_nxt = OWN0;
                else if (m1_req)
                    state_nxt = OWN1;
                else
                    state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            hold_cnt <= '0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            arb_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            m0_gnt   <= (state_nxt == OWN0);
            m1_gnt   <= (state_nxt == OWN1);
            arb_busy <= (state_nxt != IDLE);
            if (state == OWN0 || state == OWN1) begin
                if (leave) begin
                    rr_last  <= sel1;
                    hold_cnt <= '0;
                end else if (oth_req && !own_lock && hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HOLD_WD'(1);
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // Shared port: the owner's attributes; master 0's when nobody owns it
    always_comb begin
        mem_req   = (state == OWN0 && m0_req) || (state == OWN1 && m1_req);
        mem_cs    = sel1 ? m1_cs    : m0_cs;
        mem_addr  = sel1 ? m1_addr  : m0_addr;
        mem_we    = sel1 ? m1_we    : m0_we;
        mem_wmask = sel1 ? m1_wmask : m0_wmask;
        mem_wdata = sel1 ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_v0 <= 1'b0;
            rd_o0 <= 1'b0;
            rd_v1 <= 1'b0;
            rd_o1 <= 1'b0;
        end else begin
            rd_v0 <= mem_req & ~mem_we;
            rd_o0 <= sel1;
            rd_v1 <= rd_v0;
            rd_o1 <= rd_o0;
        end
    end

    assign m0_rvalid = rd_v1 & ~rd_o1;
    assign m1_rvalid = rd_v1 &  rd_o1;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mbist_mem_arb.sv
// tb_mbist_mem_arb
//   Randomized and directed stimulus for mbist_mem_arb, checked against a
//   behavioural ownership model and a read-return scoreboard. A small SRAM
//   emulator returns data derived from {cs, addr} two cycles after a read.
module tb_mbist_mem_arb;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int MH = 16;
`ifdef MBIST_ARB_TURNAROUND_EN
    localparam bit TA = 1'b1;
`else
    localparam bit TA = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          m0_req = 0, m0_lock = 0, m0_we = 0;
    logic [CW-1:0] m0_cs = '0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW/8-1:0] m0_wmask = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [CW-1:0] m1_cs = '0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW/8-1:0] m1_wmask = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_req, mem_we;
    logic [CW-1:0] mem_cs;
    logic [AW-1:0] mem_addr;
    logic [DW/8-1:0] mem_wmask;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          arb_busy;

    mbist_mem_arb #(
        .BIST_ADDR_WD(AW),
        .BIST_DATA_WD(DW),
        .BIST_CS_WD(CW),
        .MAX_HOLD(MH)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_cs(m0_cs), .m0_addr(m0_addr),
        .m0_we(m0_we), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_cs(m1_cs), .m1_addr(m1_addr),
        .m1_we(m1_we), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [DW-1:0] fdata(input logic [CW+AW-1:0] k);
        return (DW'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // SRAM emulator: read data appears two cycles after an accepted read
    logic          p0v = 1'b0, p1v = 1'b0;
    logic [CW+AW-1:0] p0a = '0, p1a = '0;
    logic [DW-1:0] junk = '0;
    always @(posedge clk) begin
        p1v  <= p0v;
        p1a  <= p0a;
        p0v  <= mem_req & ~mem_we;
        p0a  <= {mem_cs, mem_addr};
        junk <= $urandom;
    end
    assign mem_rdata = p1v ? fdata(p1a) : junk;

    // Behavioural model: own = 0/1 owner, 2 idle, 3 turnaround
    int own  = 2;
    int last = 1;
    int held = 0;

    typedef struct {
        int          owner;
        int unsigned due;
        logic [DW-1:0] data;
    } rd_t;
    rd_t sbq[$];

    task automatic model_step();
        bit r [2];
        bit l [2];
        int n, o;
        r[0] = m0_req; r[1] = m1_req;
        l[0] = m0_lock; l[1] = m1_lock;
        if (own >= 2) begin
            if (r[0] && r[1]) own = (last == 1) ? 0 : 1;
            else if (r[0])    own = 0;
            else if (r[1])    own = 1;
            else              own = 2;
            held = 0;
        end else begin
            n = own;
            o = 1 - n;
            if (!l[n] && (!r[n] || held == MH)) begin
                last = n;
                held = 0;
                own  = TA ? 3 : (r[o] ? o : 2);
            end else if (r[o] && !l[n] && held < MH) begin
                held++;
            end
        end
    endtask

    // Called just after a negedge with inputs set; ends at the next negedge
    task automatic tick();
        bit sel;
        rd_t e;
        #1;
        sel = (own == 1);
        check("m0_gnt", m0_gnt, own == 0);
        check("m1_gnt", m1_gnt, own == 1);
        check("arb_busy", arb_busy, own != 2);
        check("mem_req", mem_req, (own == 0 && m0_req) || (own == 1 && m1_req));
        check("mem_cs", mem_cs, sel ? m1_cs : m0_cs);
        check("mem_addr", mem_addr, sel ? m1_addr : m0_addr);
        check("mem_we", mem_we, sel ? m1_we : m0_we);
        check("mem_wmask", mem_wmask, sel ? m1_wmask : m0_wmask);
        check("mem_wdata", mem_wdata, sel ? m1_wdata : m0_wdata);
        if (own == 0 && m0_req && !m0_we) begin
            e.owner = 0; e.due = cyc + 2; e.data = fdata({m0_cs, m0_addr});
            sbq.push_back(e);
        end else if (own == 1 && m1_req && !m1_we) begin
            e.owner = 1; e.due = cyc + 2; e.data = fdata({m1_cs, m1_addr});
            sbq.push_back(e);
        end
        model_step();
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        m0_req = 0; m0_lock = 0; m0_we = 0;
        m1_req = 0; m1_lock = 0; m1_we = 0;
    endtask

    // Called just after a negedge; releases reset at a later negedge
    task automatic do_reset();
        rst = 1'b1;
        zero_inputs();
        #1;
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_busy", arb_busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        own = 2; last = 1; held = 0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_inputs(input int p_flip, input bit allow_lock);
        if ($urandom_range(99) < p_flip) m0_req = ~m0_req;
        if ($urandom_range(99) < p_flip) m1_req = ~m1_req;
        if (allow_lock && $urandom_range(99) < 4) m0_lock = ~m0_lock;
        if (allow_lock && $urandom_range(99) < 4) m1_lock = ~m1_lock;
        if (!allow_lock) begin m0_lock = 0; m1_lock = 0; end
        m0_we = 1'($urandom);        m1_we = 1'($urandom);
        m0_cs = CW'($urandom);       m1_cs = CW'($urandom);
        m0_addr = AW'($urandom);     m1_addr = AW'($urandom);
        m0_wmask = (DW/8)'($urandom); m1_wmask = (DW/8)'($urandom);
        m0_wdata = $urandom;         m1_wdata = $urandom;
    endtask

    // Scoreboard monitor: compares read returns independently of stimulus
    always @(posedge clk) begin
        bit e0, e1;
        logic [DW-1:0] d;
        #3;
        e0 = 0; e1 = 0; d = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e0 = (sbq[0].owner == 0);
            e1 = (sbq[0].owner == 1);
            d  = sbq[0].data;
            void'(sbq.pop_front());
        end
        check("m0_rvalid", m0_rvalid, e0);
        check("m1_rvalid", m1_rvalid, e1);
        if (e0) check("m0_rdata", m0_rdata, d);
        if (e1) check("m1_rdata", m1_rdata, d);
    end

    initial begin
        zero_inputs();
        repeat (3) @(negedge clk);
        do_reset();

        // single master 0 request, then release
        m0_addr = 9'h055; m0_cs = 2'd1; m0_we = 0;
        m0_req = 1; repeat (3) tick();
        m0_req = 0; repeat (3) tick();

        // simultaneous requests: m0 first, then m1, next tie to m0
        do_reset();
        m0_req = 1; m1_req = 1; m1_we = 1; repeat (3) tick();
        m0_req = 0; repeat (3) tick();
        m1_req = 0; repeat (3) tick();
        m0_req = 1; m1_req = 1; repeat (3) tick();
        zero_inputs(); repeat (4) tick();

        // preemption of m1 after MAX_HOLD, then locked m1 keeps the port
        do_reset();
        m1_req = 1; tick();
        m0_req = 1; repeat (25) tick();
        zero_inputs(); repeat (4) tick();
        do_reset();
        m1_req = 1; m1_lock = 1; tick();
        m0_req = 1; repeat (100) tick();
        m1_lock = 0; repeat (25) tick();
        zero_inputs(); repeat (4) tick();

        // read in flight across an ownership change
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 9'h010; m0_cs = 2'd0; tick();
        m1_req = 1; m1_we = 1; tick();
        m0_req = 0; repeat (5) tick();
        zero_inputs(); repeat (3) tick();

        // reset one cycle after a read is issued
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 9'h1A3; tick(); tick();
        do_reset();
        repeat (5) tick();

        // randomized traffic with sporadic resets
        for (int i = 0; i < 3000; i++) begin
            rand_inputs(20, (i % 1000) >= 500);
            tick();
            if ($urandom_range(399) == 0) do_reset();
        end
        zero_inputs();
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
